des_dec_key_sched: RTL and testbench

DES_DEC_KEY_SCHED -- requirements
Module: des_dec_key_sched

---
 rtl/des_pkg.sv | 67 ++++++
 rtl/perm2.sv | 13 +
 rtl/des_dec_key_sched.sv | 93 +++++++++
 tb/tb_des_dec_key_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 tables, shift schedule, state enum,
// plus the PC-1 and 28-bit rotate helpers used by the decryption key scheduler.
package des_pkg;

    localparam int KEY_W   = 64;
    localparam int CD_W    = 56;
    localparam int HALF_W  = 28;
    localparam int RK_W    = 48;
    localparam int ROUND_W = 5;

    localparam logic [ROUND_W-1:0] LAST_ROUND = 5'd16;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Table entries use DES numbering: bit 1 is the MSB of the source vector.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Entry 0 is the left shift applied for encryption round 1.
    localparam int SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [CD_W-1:0] res;
        res = '0;
        for (int i = 0; i < CD_W; i++) begin
            res[6'(CD_W - 1 - i)] = k[6'(KEY_W - PC1_TAB[i])];
        end
        return res;
    endfunction

    // Decryption round rnd undoes encryption shift number 17-rnd; true when that is 2.
    function automatic logic dec_shift_two(input logic [ROUND_W-1:0] rnd);
        int idx;
        idx = 16 - int'(rnd);
        if (idx >= 0 && idx <= 15) begin
            return SHIFT_TAB[4'(idx)] == 2;
        end
        return 1'b0;
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic two);
        return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
    endfunction

endpackage

// File: rtl/perm2.sv
// PC-2 compression permutation: 56-bit {C,D} to a 48-bit round key (k[47] = PC-2 bit 1).
module perm2
    import des_pkg::*;
(
    input  logic [CD_W-1:0] cd,
    output logic [RK_W-1:0] k
);

    for (genvar i = 0; i < RK_W; i++) begin : g_pc2
        assign k[RK_W-1-i] = cd[CD_W-PC2_TAB[i]];
    end

endmodule

// File: rtl/des_dec_key_sched.sv
// DES decryption key scheduler: emits K16..K1 one per valid/ready handshake,
// walking C/D backwards with right rotations starting from C16/D16 = C0/D0.
module des_dec_key_sched
    import des_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_W-1:0]   key,
    input  logic               start,
    input  logic               r_key_ready,
    output logic [RK_W-1:0]    r_key,
    output logic               r_key_valid,
    output logic [ROUND_W-1:0] round,
    output logic               busy,
    output logic               done
);

    state_t               state, state_n;
    logic [HALF_W-1:0]    c_q, d_q, c_n, d_n;
    logic [ROUND_W-1:0]   round_q, round_n;
    logic                 done_q, done_n;
    logic [CD_W-1:0]      pc1_key;
    logic [RK_W-1:0]      pc2_key;
    logic                 hs;
    logic                 two;

    // Handshake: a key transfers on a rising edge where r_key_valid and r_key_ready
    // are both high; valid never drops and r_key/round never change until it does.
    assign hs      = r_key_valid & r_key_ready;
    assign pc1_key = pc1(key);
    assign two     = dec_shift_two(round_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            c_q     <= c_n;
            d_q     <= d_n;
            round_q <= round_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        c_n     = c_q;
        d_n     = d_q;
        round_n = round_q;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = EMIT;
                    c_n     = pc1_key[CD_W-1:HALF_W];
                    d_n     = pc1_key[HALF_W-1:0];
                    round_n = ROUND_W'(1);
                end
            end
            EMIT: begin
                if (hs) begin
                    if (round_q == LAST_ROUND) begin
                        // C/D are left as-is; the IDLE output gate hides them.
                        state_n = IDLE;
                        round_n = '0;
                        done_n  = 1'b1;
                    end else begin
                        c_n     = rotr(c_q, two);
                        d_n     = rotr(d_q, two);
                        round_n = round_q + ROUND_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    perm2 u_perm2 (
        .cd ({c_q, d_q}),
        .k  (pc2_key)
    );

    assign r_key_valid = (state == EMIT);
    assign busy        = (state != IDLE);
    assign r_key       = r_key_valid ? pc2_key : '0;
    assign round       = round_q;
    assign done        = done_q;

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Directed bench for des_dec_key_sched: hand-computed key table, an independent
// forward-schedule model for a second key, stalls, ignored restart, abort and chaining.
module tb_des_dec_key_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        r_key_ready = 1'b0;
    logic [63:0] key = '0;
    logic [47:0] r_key;
    logic        r_key_valid;
    logic [4:0]  round;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    logic [47:0] exp_q[$];

    typedef struct packed {
        logic [4:0]  rnd;
        logic [47:0] rk;
    } vec_t;
    vec_t vec [16];

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
    localparam logic [63:0] KEY_C = 64'hFEDCBA9876543210;

    localparam int M_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int M_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int M_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // clock / reset
    always #5 clk = ~clk;

    des_dec_key_sched dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .start       (start),
        .r_key_ready (r_key_ready),
        .r_key       (r_key),
        .r_key_valid (r_key_valid),
        .round       (round),
        .busy        (busy),
        .done        (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " valid"}, 64'(r_key_valid), 64'(0));
        check({tag, " busy"},  64'(busy),        64'(0));
        check({tag, " round"}, 64'(round),       64'(0));
        check({tag, " r_key"}, 64'(r_key),       64'(0));
    endtask

    // Forward encryption schedule (left rotations), queued in decryption order.
    task automatic model_keys(input logic [63:0] k);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = k[6'(64 - M_PC1[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < M_SH[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) ks[r][6'(47 - j)] = cd[6'(56 - M_PC2[j])];
        end
        exp_q.delete();
        for (int r = 15; r >= 0; r--) exp_q.push_back(ks[r]);
    endtask

    task automatic load_table();
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(vec[i].rk);
    endtask

    // driver: present key with a one-cycle start pulse
    task automatic begin_sched(input logic [63:0] k);
        key   = k;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Consumes exp_q with random stalls; returns on the done cycle (or after abort).
    task automatic stream(input int stall_pct, input int repulse_round, input int abort_round,
                          input string tag);
        int exp_round = 1;
        int cycles    = 0;
        bit pulsed    = 1'b0;
        while (exp_q.size() > 0 && cycles < 400) begin
            r_key_ready = ($urandom_range(0, 99) >= stall_pct);
            check({tag, " valid"}, 64'(r_key_valid), 64'(1));
            check({tag, " round"}, 64'(round),       64'(exp_round));
            check({tag, " r_key"}, 64'(r_key),       64'(exp_q[0]));
            if (exp_round == abort_round) begin
                rst = 1'b1;
                #1;
                check_idle({tag, " abort"});
                check({tag, " abort done"}, 64'(done), 64'(0));
                step();
                check({tag, " abort done+1"}, 64'(done), 64'(0));
                check_idle({tag, " abort+1"});
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            if (exp_round == repulse_round && !pulsed) begin
                start  = 1'b1;
                key    = KEY_C;
                pulsed = 1'b1;
            end
            step();
            start = 1'b0;
            if (r_key_ready) begin
                void'(exp_q.pop_front());
                exp_round++;
            end
            cycles++;
        end
        check({tag, " timeout"}, 64'(exp_q.size()), 64'(0));
        check({tag, " done"}, 64'(done), 64'(1));
        check_idle({tag, " end"});
    endtask

    initial begin
        vec[0]  = '{rnd: 5'd1,  rk: 48'hCB3D8B0E17F5};
        vec[1]  = '{rnd: 5'd2,  rk: 48'hBF918D3D3F0A};
        vec[2]  = '{rnd: 5'd3,  rk: 48'h5F43B7F2E73A};
        vec[3]  = '{rnd: 5'd4,  rk: 48'h97C5D1FABA41};
        vec[4]  = '{rnd: 5'd5,  rk: 48'h7571F59467E9};
        vec[5]  = '{rnd: 5'd6,  rk: 48'h215FD3DED386};
        vec[6]  = '{rnd: 5'd7,  rk: 48'hB1F347BA464F};
        vec[7]  = '{rnd: 5'd8,  rk: 48'hE0DBEBEDE781};
        vec[8]  = '{rnd: 5'd9,  rk: 48'hF78A3AC13BFB};
        vec[9]  = '{rnd: 5'd10, rk: 48'hEC84B7F618BC};
        vec[10] = '{rnd: 5'd11, rk: 48'h63A53E507B2F};
        vec[11] = '{rnd: 5'd12, rk: 48'h7CEC07EB53A8};
        vec[12] = '{rnd: 5'd13, rk: 48'h72ADD6DB351D};
        vec[13] = '{rnd: 5'd14, rk: 48'h55FC8A42CF99};
        vec[14] = '{rnd: 5'd15, rk: 48'h79AED9DBC9E5};
        vec[15] = '{rnd: 5'd16, rk: 48'h1B02EFFC7072};

        // reset state, including while held
        #1;
        check_idle("reset");
        check("reset done", 64'(done), 64'(0));
        step();
        step();
        rst = 1'b0;
        step();
        check_idle("post-reset");

        // table pass: ready held high, one key per cycle, latency 1 from start
        r_key_ready = 1'b1;
        begin_sched(KEY_A);
        for (int i = 0; i < 16; i++) begin
            check("tbl valid", 64'(r_key_valid), 64'(1));
            check("tbl round", 64'(round),       64'(vec[i].rnd));
            check("tbl r_key", 64'(r_key),       64'(vec[i].rk));
            step();
        end
        check("tbl done", 64'(done), 64'(1));
        check_idle("tbl end");
        step();
        check("tbl done pulse width", 64'(done), 64'(0));

        // random stalls on the hand table and on a model-generated key
        load_table();
        begin_sched(KEY_A);
        stream(30, 0, 0, "stall A");
        step();
        check("stall A done+1", 64'(done), 64'(0));

        model_keys(KEY_B);
        begin_sched(KEY_B);
        stream(30, 0, 0, "stall B");
        step();

        // restart with a new key while busy is ignored
        load_table();
        begin_sched(KEY_A);
        stream(20, 5, 0, "repulse");
        step();

        // abort during round 9, then a fresh schedule restarts at K16
        load_table();
        begin_sched(KEY_A);
        stream(0, 0, 9, "abort");
        check("abort idle gap done", 64'(done), 64'(0));
        load_table();
        begin_sched(KEY_A);
        stream(0, 0, 0, "after abort");
        step();

        // back-to-back: start asserted on the done cycle
        load_table();
        begin_sched(KEY_A);
        stream(10, 0, 0, "b2b first");
        model_keys(KEY_B);
        begin_sched(KEY_B);
        stream(10, 0, 0, "b2b second");
        step();
        check("b2b done+1", 64'(done), 64'(0));
        check_idle("b2b idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
